bt656_stream_tx: RTL and testbench
==================================

Name: bt656_stream_tx

Overview:
- Parametrised successor BT.656 serializer: same EAV/blank/SAV/active line structure and field/line timing, plus real pixel data from an upstream valid/ready stream instead of a fixed test pattern.
- Adds 8/10-bit output, a byte-strobe/clock-enable output in place of a derived clock, underflow detection, and clean start/stop at frame boundaries.
- Sits between the video pipeline (CbYCrY byte stream) and the parallel video pad interface.

Parameters:
- DATA_WIDTH, 8, output/input word width; legal values 8 or 10.
- CLK_DIV, 4, i_SysClock cycles per output byte (>=1); 1 means a byte every cycle.
- HACT_BYTES, 1440, active bytes per line (multiple of 4).
- HBLK_BYTES, 276, horizontal blanking bytes including the 4-byte EAV and 4-byte SAV (multiple of 4, >=8).
- VACT_LINES_F1, 240, active lines in field 1.
- VBLK_F1_TOP, 18, blank lines before active video, field 1.
- VBLK_F1_BOT, 4, blank lines after active video, field 1.
- VACT_LINES_F2, 240, active lines in field 2.
- VBLK_F2_TOP, 18, blank lines before active video, field 2.
- VBLK_F2_BOT, 5, blank lines after active video, field 2.

Ports:
- i_SysClock  in  1  sole clock.
- i_ResetN  in  1  asynchronous active-low reset.
- i_Enable  in  1  level; start/continue transmission.
- i_InterlaceMode  in  1  1 = two fields per frame, 0 = progressive (field 1 only).
- i_PixData  in  DATA_WIDTH  active-video byte, CbYCrY order.
- i_PixValid  in  1  upstream data valid.
- o_PixReady  out  1  byte consumed this cycle if i_PixValid=1.
- i_ClearUnderflow  in  1  clears o_Underflow.
- o_Data  out  DATA_WIDTH  BT.656 byte.
- o_DataStrobe  out  1  one-cycle pulse when o_Data holds a new byte.
- o_Hsignal  out  1  H bit of the current byte's region.
- o_Vsignal  out  1  V bit of the current byte's region.
- o_Fsignal  out  1  F bit of the current byte's region.
- o_FrameStart  out  1  pulse with the first EAV byte of field 1, line 0.
- o_Underflow  out  1  sticky; active byte needed but no valid data.

Behaviour:
- Reset: all outputs 0 except o_Hsignal=1 and o_Vsignal=1; state IDLE, all counters 0.
- Prescaler counts 0..CLK_DIV-1; "tick" is asserted when the count equals CLK_DIV-1. All counters and state advance only on ticks.
- States:
  - IDLE to RUN on a tick with i_Enable=1: line 0, byte 0, field 1; i_InterlaceMode is latched at that tick.
  - RUN to IDLE only at the last byte of a frame while i_Enable=0. Frame end is field 1 end when progressive, field 2 end when interlaced.
  - i_InterlaceMode is re-latched at every frame boundary.
- Horizontal byte index b, range 0..HBLK_BYTES+HACT_BYTES-1, then wraps:
  - b 0..3: EAV.
  - b 4..HBLK_BYTES-5: blank fill.
  - b HBLK_BYTES-4..HBLK_BYTES-1: SAV.
  - b >= HBLK_BYTES: active region.
- Line counter:
  - Increments at b wrap; wraps at field total lines - 1, where total = TOP + VACT + BOT of that field.
  - At field wrap, F toggles when interlaced and stays 0 when progressive.
  - V=1 for line < TOP or line >= TOP+VACT.
- Sync words:
  - 8-bit: FF,00,00,XY with XY = {1,F,V,H,V^H,F^H,F^V,F^V^H}; H=1 for EAV, 0 for SAV.
  - 10-bit: 3FF,000,000,{XY,2'b00}.
- Blank fill: alternate 80/10 (10-bit: 200/040), starting with 80 at b=4.
- Active region on V=0 lines:
  - o_PixReady = tick in that region.
  - Transfer when i_PixValid & o_PixReady; output byte = i_PixData.
  - If i_PixValid=0 at such a tick: output black (80 on even b-HBLK_BYTES, 10 on odd; 10-bit 200/040) and set o_Underflow.
- Active region on V=1 lines: blank fill, o_PixReady=0.
- o_PixReady is 0 in IDLE and in every other region.
- Latency: a byte selected at tick cycle t drives o_Data/H/V/F/o_DataStrobe (and o_FrameStart where applicable) at t+1, all registered. A pixel accepted at t appears at t+1.
- IDLE outputs: o_Data=0, o_DataStrobe=0, o_Hsignal=o_Vsignal=1, o_Fsignal=0.
- o_Underflow: set has priority over i_ClearUnderflow in the same cycle.
- i_Enable dropped mid-frame: the frame completes normally, including active data requests.
- Reset mid-frame: immediate asynchronous return to reset values. No partial-byte hold.

Test Plan:
Test parameters: HACT_BYTES=8, HBLK_BYTES=12, all VACT=2, all TOP=1, all BOT=1, CLK_DIV=2.
- Progressive, i_Enable=1, source always valid with bytes 01..08 → line 0 (V=1) bytes 0-3 FF,00,00,B6; 4-7 80,10,80,10; 8-11 FF,00,00,AB; 12-19 80/10 blank, o_PixReady=0. Line 1 EAV XY=9D, SAV XY=80, active 01..08. o_DataStrobe every 2 cycles; o_FrameStart once per 4 lines.
- Interlace=1 → field 2 lines carry F=1: EAV XY F1 (V=1) or DA (V=0), SAV XY EC (V=1) or C7 (V=0); F returns to 0 after 8 lines; o_FrameStart once per 8 lines.
- i_PixValid=0 for byte 2 of an active line → o_Data 80,10,80,... for that position, o_Underflow=1 until i_ClearUnderflow; no extra byte consumed.
- i_Enable dropped at line 1 → transmission continues to end of line 3, then IDLE outputs; no strobes afterwards.
- DATA_WIDTH=10, CLK_DIV=1 → EAV 3FF,000,000,2D8 on line 0; a strobe every cycle.
- i_ResetN low mid-active-line → all outputs at reset values immediately; restart begins at line 0 EAV.

Source files
------------

// File: rtl/bt656_stream_tx.sv
// BT.656 serializer: EAV/blank/SAV/active line framing around a CbYCrY valid/ready pixel stream.
// One byte every CLK_DIV clocks, with a strobe and H/V/F flags registered alongside each byte.
module bt656_stream_tx #(
   parameter int DATA_WIDTH    = 8,
   parameter int CLK_DIV       = 4,
   parameter int HACT_BYTES    = 1440,
   parameter int HBLK_BYTES    = 276,
   parameter int VACT_LINES_F1 = 240,
   parameter int VBLK_F1_TOP   = 18,
   parameter int VBLK_F1_BOT   = 4,
   parameter int VACT_LINES_F2 = 240,
   parameter int VBLK_F2_TOP   = 18,
   parameter int VBLK_F2_BOT   = 5
) (
   input  logic                  i_SysClock,
   input  logic                  i_ResetN,
   input  logic                  i_Enable,
   input  logic                  i_InterlaceMode,
   input  logic [DATA_WIDTH-1:0] i_PixData,
   input  logic                  i_PixValid,
   output logic                  o_PixReady,
   input  logic                  i_ClearUnderflow,
   output logic [DATA_WIDTH-1:0] o_Data,
   output logic                  o_DataStrobe,
   output logic                  o_Hsignal,
   output logic                  o_Vsignal,
   output logic                  o_Fsignal,
   output logic                  o_FrameStart,
   output logic                  o_Underflow
);

   localparam int LINE_BYTES = HBLK_BYTES + HACT_BYTES;
   localparam int F1_LINES   = VBLK_F1_TOP + VACT_LINES_F1 + VBLK_F1_BOT;
   localparam int F2_LINES   = VBLK_F2_TOP + VACT_LINES_F2 + VBLK_F2_BOT;
   localparam int MAX_LINES  = (F1_LINES > F2_LINES) ? F1_LINES : F2_LINES;
   localparam int BW         = $clog2(LINE_BYTES);
   localparam int LW         = $clog2(MAX_LINES + 1);
   localparam int PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] B_EAV_END  = BW'(4);
   localparam logic [BW-1:0] B_SAV      = BW'(HBLK_BYTES - 4);
   localparam logic [BW-1:0] B_ACT      = BW'(HBLK_BYTES);
   localparam logic [BW-1:0] B_LAST     = BW'(LINE_BYTES - 1);
   localparam logic [LW-1:0] F1_TOP_END = LW'(VBLK_F1_TOP);
   localparam logic [LW-1:0] F1_ACT_END = LW'(VBLK_F1_TOP + VACT_LINES_F1);
   localparam logic [LW-1:0] F1_LAST    = LW'(F1_LINES - 1);
   localparam logic [LW-1:0] F2_TOP_END = LW'(VBLK_F2_TOP);
   localparam logic [LW-1:0] F2_ACT_END = LW'(VBLK_F2_TOP + VACT_LINES_F2);
   localparam logic [LW-1:0] F2_LAST    = LW'(F2_LINES - 1);
   localparam logic [DATA_WIDTH-1:0] FILL_EVEN = DATA_WIDTH'(32'h80 << (DATA_WIDTH - 8));
   localparam logic [DATA_WIDTH-1:0] FILL_ODD  = DATA_WIDTH'(32'h10 << (DATA_WIDTH - 8));

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           pre_q, pre_d;
   logic [BW-1:0]           b_q, b_d;
   logic [LW-1:0]           line_q, line_d;
   logic                    field_q, field_d;
   logic                    il_q, il_d;
   logic [DATA_WIDTH-1:0]   data_d;
   logic                    strobe_d, h_d, v_d, f_d, fs_d, unf_d;

   logic                    tick, v_bit, h_bit, in_eav, in_sav, in_act;
   logic                    line_end, field_end, frame_end;
   logic [LW-1:0]           top_end, act_end, line_last;
   logic [7:0]              xy;
   logic [DATA_WIDTH-1:0]   xy_word, sync_word, fill_word, byte_sel;

   always_comb begin
      tick      = (pre_q == PRE_LAST);
      pre_d     = tick ? '0 : pre_q + PW'(1);

      top_end   = field_q ? F2_TOP_END : F1_TOP_END;
      act_end   = field_q ? F2_ACT_END : F1_ACT_END;
      line_last = field_q ? F2_LAST    : F1_LAST;
      v_bit     = (line_q < top_end) || (line_q >= act_end);
      h_bit     = (b_q < B_SAV);
      in_eav    = (b_q < B_EAV_END);
      in_sav    = (b_q >= B_SAV) && (b_q < B_ACT);
      in_act    = (b_q >= B_ACT);
      line_end  = (b_q == B_LAST);
      field_end = line_end && (line_q == line_last);
      frame_end = field_end && (field_q || !il_q);

      xy        = {1'b1, field_q, v_bit, h_bit, v_bit ^ h_bit, field_q ^ h_bit,
                   field_q ^ v_bit, field_q ^ v_bit ^ h_bit};
      xy_word   = DATA_WIDTH'({24'd0, xy} << (DATA_WIDTH - 8));
      // EAV and SAV both start on a multiple of 4, so the low index bits select the word
      case (b_q[1:0])
         2'd0:    sync_word = '1;
         2'd1,
         2'd2:    sync_word = '0;
         default: sync_word = xy_word;
      endcase
      fill_word = b_q[0] ? FILL_ODD : FILL_EVEN;

      o_PixReady = tick && (state_q == S_RUN) && in_act && !v_bit;

      if (in_eav || in_sav)       byte_sel = sync_word;
      else if (in_act && !v_bit)  byte_sel = i_PixValid ? i_PixData : fill_word;
      else                        byte_sel = fill_word;

      state_d  = state_q;
      b_d      = b_q;
      line_d   = line_q;
      field_d  = field_q;
      il_d     = il_q;
      data_d   = o_Data;
      strobe_d = 1'b0;
      h_d      = o_Hsignal;
      v_d      = o_Vsignal;
      f_d      = o_Fsignal;
      fs_d     = 1'b0;
      unf_d    = (o_Underflow && !i_ClearUnderflow) || (o_PixReady && !i_PixValid);

      if (tick) begin
         if (state_q == S_IDLE && !i_Enable) begin
            data_d = '0;
            h_d    = 1'b1;
            v_d    = 1'b1;
            f_d    = 1'b0;
         end else begin
            // the enabling tick already emits byte 0 of line 0, field 1
            if (state_q == S_IDLE) begin
               state_d = S_RUN;
               il_d    = i_InterlaceMode;
            end else if (frame_end && !i_Enable) begin
               state_d = S_IDLE;
            end
            data_d   = byte_sel;
            strobe_d = 1'b1;
            h_d      = h_bit;
            v_d      = v_bit;
            f_d      = field_q;
            fs_d     = (b_q == '0) && (line_q == '0) && !field_q;

            if (line_end) begin
               b_d = '0;
               if (field_end) begin
                  line_d = '0;
                  if (frame_end) begin
                     field_d = 1'b0;
                     il_d    = i_InterlaceMode;
                  end else begin
                     field_d = 1'b1;
                  end
               end else begin
                  line_d = line_q + LW'(1);
               end
            end else begin
               b_d = b_q + BW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_SysClock or negedge i_ResetN) begin
      if (!i_ResetN) begin
         state_q      <= S_IDLE;
         pre_q        <= '0;
         b_q          <= '0;
         line_q       <= '0;
         field_q      <= 1'b0;
         il_q         <= 1'b0;
         o_Data       <= '0;
         o_DataStrobe <= 1'b0;
         o_Hsignal    <= 1'b1;
         o_Vsignal    <= 1'b1;
         o_Fsignal    <= 1'b0;
         o_FrameStart <= 1'b0;
         o_Underflow  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pre_q        <= pre_d;
         b_q          <= b_d;
         line_q       <= line_d;
         field_q      <= field_d;
         il_q         <= il_d;
         o_Data       <= data_d;
         o_DataStrobe <= strobe_d;
         o_Hsignal    <= h_d;
         o_Vsignal    <= v_d;
         o_Fsignal    <= f_d;
         o_FrameStart <= fs_d;
         o_Underflow  <= unf_d;
      end
   end

endmodule

// File: tb/tb_bt656_stream_tx.sv
// Bench for bt656_stream_tx on a reduced 20-byte x 4-line field, 8-bit/CLK_DIV=2 and 10-bit/CLK_DIV=1.
// Expected bytes come from a frame model pushed to a queue and popped on every output strobe.
module tb_bt656_stream_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, en, il, pix_valid, pix_ready, clr_unf;
   logic [7:0] pix_data, data;
   logic       strobe, h, v, f, fs, unf;
   logic       en10, pix_ready10, strobe10, h10, v10, f10, fs10, unf10;
   logic [9:0] data10;

   bt656_stream_tx #(
      .DATA_WIDTH(8), .CLK_DIV(2), .HACT_BYTES(8), .HBLK_BYTES(12),
      .VACT_LINES_F1(2), .VBLK_F1_TOP(1), .VBLK_F1_BOT(1),
      .VACT_LINES_F2(2), .VBLK_F2_TOP(1), .VBLK_F2_BOT(1)
   ) u_dut (
      .i_SysClock(clk), .i_ResetN(rst_n), .i_Enable(en), .i_InterlaceMode(il),
      .i_PixData(pix_data), .i_PixValid(pix_valid), .o_PixReady(pix_ready),
      .i_ClearUnderflow(clr_unf), .o_Data(data), .o_DataStrobe(strobe),
      .o_Hsignal(h), .o_Vsignal(v), .o_Fsignal(f), .o_FrameStart(fs), .o_Underflow(unf)
   );

   bt656_stream_tx #(
      .DATA_WIDTH(10), .CLK_DIV(1), .HACT_BYTES(8), .HBLK_BYTES(12),
      .VACT_LINES_F1(2), .VBLK_F1_TOP(1), .VBLK_F1_BOT(1),
      .VACT_LINES_F2(2), .VBLK_F2_TOP(1), .VBLK_F2_BOT(1)
   ) u_dut10 (
      .i_SysClock(clk), .i_ResetN(rst_n), .i_Enable(en10), .i_InterlaceMode(1'b0),
      .i_PixData(10'h000), .i_PixValid(1'b0), .o_PixReady(pix_ready10),
      .i_ClearUnderflow(1'b0), .o_Data(data10), .o_DataStrobe(strobe10),
      .o_Hsignal(h10), .o_Vsignal(v10), .o_Fsignal(f10), .o_FrameStart(fs10), .o_Underflow(unf10)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       h, v, f, fs;
   } exp_t;

   exp_t q[$];
   int   total = 0, bad = 0;
   int   cyc = 0, last_strobe = -1, strobes_seen = 0, fs_seen = 0, byte_no = 0;
   // pixel source
   bit   src_on, drop_done, hs_pending, refuse_pending;
   int   src_val, src_idx, drop_pos;
   // frame model
   int   m_val, m_idx, m_drop;
   bit   m_dropped;

   function automatic logic [7:0] xy_code(input logic fb, input logic vb, input logic hb);
      case ({fb, vb, hb})
         3'b011:  return 8'hB6;
         3'b010:  return 8'hAB;
         3'b001:  return 8'h9D;
         3'b000:  return 8'h80;
         3'b111:  return 8'hF1;
         3'b110:  return 8'hEC;
         3'b101:  return 8'hDA;
         default: return 8'hC7;
      endcase
   endfunction

   task automatic push_field(input logic fb);
      exp_t e;
      for (int l = 0; l < 4; l++) begin
         for (int b = 0; b < 20; b++) begin
            e.v  = (l == 0) || (l == 3);
            e.f  = fb;
            e.h  = (b < 8);
            e.fs = (!fb && l == 0 && b == 0);
            if (b < 4 || (b >= 8 && b < 12)) begin
               case (b % 4)
                  0:       e.d = 8'hFF;
                  3:       e.d = xy_code(fb, e.v, e.h);
                  default: e.d = 8'h00;
               endcase
            end else if (b >= 12 && !e.v) begin
               if (m_idx == m_drop && !m_dropped) begin
                  e.d = (b % 2 == 0) ? 8'h80 : 8'h10;
                  m_dropped = 1'b1;
               end else begin
                  e.d = 8'(m_val);
                  m_val++;
                  m_idx++;
               end
            end else begin
               e.d = (b % 2 == 0) ? 8'h80 : 8'h10;
            end
            q.push_back(e);
         end
      end
   endtask

   task automatic push_frame(input logic ilace);
      push_field(1'b0);
      if (ilace) push_field(1'b1);
   endtask

   task automatic cycle();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (strobe) begin
         strobes_seen++;
         if (fs) fs_seen++;
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: got data=%h h=%b v=%b f=%b, required no strobe", data, h, v, f);
         end else begin
            e = q.pop_front();
            if ({data, h, v, f, fs} !== e) begin
               bad++;
               $display("FAIL byte_%0d: got data=%h h=%b v=%b f=%b fs=%b, required data=%h h=%b v=%b f=%b fs=%b",
                        byte_no, data, h, v, f, fs, e.d, e.h, e.v, e.f, e.fs);
            end
         end
         byte_no++;
         if (last_strobe >= 0) begin
            total++;
            if (cyc - last_strobe !== 2) begin
               bad++;
               $display("FAIL strobe_gap: got %0d cycles, required 2", cyc - last_strobe);
            end
         end
         last_strobe = cyc;
      end
      if (hs_pending) begin
         src_val++;
         src_idx++;
      end
      if (refuse_pending) drop_done = 1'b1;
      pix_valid      = src_on && !(src_idx == drop_pos && !drop_done);
      pix_data       = 8'(src_val);
      hs_pending     = pix_valid && pix_ready;
      refuse_pending = src_on && !pix_valid && pix_ready;
   endtask

   task automatic run_until(input int left, input int max_cycles, input string name);
      int n = 0;
      while (q.size() > left && n < max_cycles) begin
         cycle();
         n++;
      end
      total++;
      if (q.size() > left) begin
         bad++;
         $display("FAIL %s_timeout: got %0d bytes pending after %0d cycles, required %0d", name, q.size(), n, left);
      end
   endtask

   task automatic clear_source();
      src_on = 1'b0; pix_valid = 1'b0; pix_data = 8'h00;
      src_val = 1; src_idx = 0; drop_pos = -1; drop_done = 1'b0;
      hs_pending = 1'b0; refuse_pending = 1'b0;
      m_val = 1; m_idx = 0; m_drop = -1; m_dropped = 1'b0;
      q.delete();
      last_strobe = -1; fs_seen = 0; byte_no = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; il = 1'b0; clr_unf = 1'b0; en10 = 1'b0;
      clear_source();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({data, strobe, h, v, f, fs, unf, pix_ready} !== {8'h00, 7'b0110000}) begin
         bad++;
         $display("FAIL reset8: got data=%h st=%b h=%b v=%b f=%b fs=%b unf=%b rdy=%b, required 00 0 1 1 0 0 0 0",
                  data, strobe, h, v, f, fs, unf, pix_ready);
      end
      total++;
      if ({data10, strobe10, h10, v10, f10, fs10, unf10} !== {10'h000, 6'b011000}) begin
         bad++;
         $display("FAIL reset10: got data=%h st=%b h=%b v=%b f=%b, required 000 0 1 1 0", data10, strobe10, h10, v10, f10);
      end
      strobes_seen = 0;
      repeat (10) cycle();
      total++;
      if (strobes_seen !== 0) begin
         bad++;
         $display("FAIL idle_quiet: got %0d strobes, required 0", strobes_seen);
      end
   endtask

   task automatic test_progressive();
      push_frame(1'b0);
      push_frame(1'b0);
      src_on = 1'b1;
      en = 1'b1;
      run_until(80, 400, "prog_frame1");
      total++;
      if (fs_seen !== 1) begin
         bad++;
         $display("FAIL prog_framestart: got %0d pulses, required 1", fs_seen);
      end
   endtask

   task automatic test_enable_drop();
      int quiet;
      run_until(60, 100, "drop_line0");
      en = 1'b0;
      run_until(0, 400, "drop_finish");
      quiet = strobes_seen;
      repeat (20) cycle();
      total++;
      if (strobes_seen !== quiet) begin
         bad++;
         $display("FAIL stop_quiet: got %0d strobes after stop, required 0", strobes_seen - quiet);
      end
      total++;
      if ({data, h, v, f, fs} !== {8'h00, 4'b1100}) begin
         bad++;
         $display("FAIL stop_idle_out: got data=%h h=%b v=%b f=%b fs=%b, required 00 1 1 0 0", data, h, v, f, fs);
      end
      total++;
      if (fs_seen !== 2) begin
         bad++;
         $display("FAIL stop_framestart: got %0d pulses, required 2", fs_seen);
      end
   endtask

   task automatic test_interlace();
      do_reset();
      il = 1'b1;
      push_frame(1'b1);
      push_frame(1'b0);
      src_on = 1'b1;
      en = 1'b1;
      run_until(160, 800, "il_field1");
      il = 1'b0;
      run_until(80, 400, "il_field2");
      total++;
      if (fs_seen !== 1) begin
         bad++;
         $display("FAIL il_framestart: got %0d pulses, required 1", fs_seen);
      end
      run_until(60, 100, "il_prog_line0");
      en = 1'b0;
      run_until(0, 400, "il_prog_finish");
      total++;
      if (fs_seen !== 2) begin
         bad++;
         $display("FAIL il_relatch_framestart: got %0d pulses, required 2", fs_seen);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      drop_pos = 2;
      m_drop = 2;
      push_frame(1'b0);
      src_on = 1'b1;
      en = 1'b1;
      run_until(46, 200, "unf_pre");
      total++;
      if (unf !== 1'b0) begin
         bad++;
         $display("FAIL unf_before: got %b, required 0", unf);
      end
      run_until(45, 10, "unf_hole");
      total++;
      if (unf !== 1'b1) begin
         bad++;
         $display("FAIL unf_set: got %b, required 1", unf);
      end
      en = 1'b0;
      run_until(0, 200, "unf_finish");
      repeat (4) cycle();
      total++;
      if (unf !== 1'b1) begin
         bad++;
         $display("FAIL unf_sticky: got %b, required 1", unf);
      end
      clr_unf = 1'b1;
      cycle();
      clr_unf = 1'b0;
      cycle();
      total++;
      if (unf !== 1'b0) begin
         bad++;
         $display("FAIL unf_clear: got %b, required 0", unf);
      end
   endtask

   task automatic test_midreset();
      do_reset();
      push_frame(1'b0);
      src_on = 1'b1;
      en = 1'b1;
      run_until(45, 200, "mr_pre");
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({data, strobe, h, v, f, fs, unf, pix_ready} !== {8'h00, 7'b0110000}) begin
         bad++;
         $display("FAIL midreset_out: got data=%h st=%b h=%b v=%b f=%b fs=%b unf=%b rdy=%b, required 00 0 1 1 0 0 0 0",
                  data, strobe, h, v, f, fs, unf, pix_ready);
      end
      clear_source();
      src_on = 1'b1;
      push_frame(1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run_until(60, 200, "mr_line0");
      en = 1'b0;
      run_until(0, 400, "mr_finish");
      total++;
      if (fs_seen !== 1) begin
         bad++;
         $display("FAIL midreset_framestart: got %0d pulses, required 1", fs_seen);
      end
   endtask

   task automatic test_10bit();
      logic [9:0] q10[$];
      logic [9:0] e;
      int         n;
      q10 = '{10'h3FF, 10'h000, 10'h000, 10'h2D8, 10'h200, 10'h040, 10'h200, 10'h040,
              10'h3FF, 10'h000, 10'h000, 10'h2AC, 10'h200, 10'h040, 10'h200, 10'h040,
              10'h200, 10'h040, 10'h200, 10'h040};
      en10 = 1'b1;
      n = 0;
      while (!strobe10 && n < 8) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!strobe10) begin
         bad++;
         $display("FAIL w10_start: got no strobe after %0d cycles, required a strobe", n);
      end
      n = 0;
      while (q10.size() > 0) begin
         e = q10.pop_front();
         total++;
         if ({strobe10, data10} !== {1'b1, e}) begin
            bad++;
            $display("FAIL w10_byte_%0d: got strobe=%b data=%h, required strobe=1 data=%h", n, strobe10, data10, e);
         end
         n++;
         @(negedge clk);
      end
      en10 = 1'b0;
      repeat (100) @(negedge clk);
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (strobe10) n++;
      end
      total++;
      if ({n[3:0], data10, h10, v10, f10} !== {4'd0, 10'h000, 3'b110}) begin
         bad++;
         $display("FAIL w10_idle: got strobes=%0d data=%h h=%b v=%b f=%b, required 0 000 1 1 0", n, data10, h10, v10, f10);
      end
   endtask

   initial begin
      test_reset();
      test_progressive();
      test_enable_drop();
      test_interlace();
      test_underflow();
      test_midreset();
      test_10bit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
